router_sync: RTL

- Sits between the router FSM/register stage and the three output FIFOs of the 1x3 router.
- Latches the 2-bit destination address at header detect and steers the FSM's write strobe to exactly one FIFO's `we`.
- Reports that FIFO's full flag back to the FSM and drives per-port `vld_out` from the FIFO empty flags.
- Generates per-port `sft_rst` pulses when a destination leaves its valid packet unread for a timeout window.

---
 rtl/router_pkg.sv | 14 +
 rtl/router_sync_timer.sv | 38 +++
 rtl/router_sync.sv | 71 +++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router synchroniser.
package router_pkg;

  localparam int NUM_PORTS       = 3;
  localparam int ADDR_W          = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
  localparam int TIMEOUT_DEFAULT = 30;

  // True when an address selects one of the real output ports.
  function automatic logic addr_is_valid(input logic [ADDR_W-1:0] addr);
    return (int'(addr) < NUM_PORTS);
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-port idle timer: pulses sft_rst for one cycle when a valid packet sits
// unread for TIMEOUT consecutive cycles.
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int CW      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd,
  output logic sft_rst
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sft_rst;

  // Count unserviced valid cycles; any read or empty FIFO restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_sft_rst <= 1'b0;
    end else if (!vld || rd) begin
      r_cnt     <= '0;
      r_sft_rst <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt     <= '0;
      r_sft_rst <= 1'b1;
    end else begin
      r_cnt     <= r_cnt + 1'b1;
      r_sft_rst <= 1'b0;
    end
  end

  assign sft_rst = r_sft_rst;

endmodule

// File: rtl/router_sync.sv
// Router synchroniser: latches the destination address at header detect,
// steers the FSM write strobe to one FIFO, returns that FIFO's full flag,
// and drives per-port valid and idle-timeout soft resets.
//
// Strobe semantics: detect_add and write_enb_reg are single-cycle qualifiers
// sampled at posedge; there is no back-pressure on them. The FSM must watch
// fifo_full and withhold write_enb_reg itself. A new address is visible to
// the write decode only from the cycle after detect_add.
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CW      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  output logic [NUM_PORTS-1:0] we,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] sft_rst
);

  logic [ADDR_W-1:0]    r_int_addr;
  logic [NUM_PORTS-1:0] w_we;
  logic                 w_fifo_full;
  logic [NUM_PORTS-1:0] w_vld;

  // Hold the packet's destination; invalid after reset so nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_addr <= ADDR_INVALID;
    end else if (detect_add) begin
      r_int_addr <= addr_in;
    end
  end

  // Decode the latched address into a one-hot write enable and full select.
  always_comb begin
    w_we        = '0;
    w_fifo_full = 1'b0;
    if (addr_is_valid(r_int_addr)) begin
      w_we[r_int_addr] = write_enb_reg;
      w_fifo_full      = full[r_int_addr];
    end
  end

  assign w_vld     = ~empty;
  assign we        = w_we;
  assign fifo_full = w_fifo_full;
  assign vld_out   = w_vld;

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .vld     (w_vld[n]),
      .rd      (read_enb[n]),
      .sft_rst (sft_rst[n])
    );
  end

endmodule
